// File: rtl/food_spawner.sv
// Picks an empty grid cell for the next food item: LFSR-random candidates first,
// then a deterministic row-major scan once MAX_TRIES candidates have missed.
module food_spawner #(
  parameter int                        GRID_WIDTH     = 40,
  parameter int                        GRID_HEIGHT    = 30,
  parameter int                        BITS_PER_BLOCK = 2,
  parameter logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY    = '0,
  parameter logic [15:0]               LFSR_SEED      = 16'hACE1,
  parameter int                        MAX_TRIES      = 16,
  localparam int                       HW             = $clog2(GRID_WIDTH),
  localparam int                       VW             = $clog2(GRID_HEIGHT)
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      SpawnReq,
  output logic                      RdEn,
  output logic [VW-1:0]             RdV,
  output logic [HW-1:0]             RdH,
  input  logic [BITS_PER_BLOCK-1:0] RdData,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Failed,
  output logic                      FoodValid,
  output logic [VW-1:0]             FoodV,
  output logic [HW-1:0]             FoodH
);

  localparam int              TW        = $clog2(MAX_TRIES + 1);
  localparam logic [15:0]     LFSR_MASK = 16'hB400;
  localparam logic [HW-1:0]   H_LAST    = HW'(GRID_WIDTH - 1);
  localparam logic [VW-1:0]   V_LAST    = VW'(GRID_HEIGHT - 1);
  localparam logic [TW-1:0]   TRIES_MAX = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CHECK,
    SCAN_RD,
    SCAN_CHK,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_next;
  logic [TW-1:0] tries_q, tries_d, tries_inc;
  logic          rd_en_q, rd_en_d;
  logic [VW-1:0] rd_v_q, rd_v_d;
  logic [HW-1:0] rd_h_q, rd_h_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          failed_q, failed_d;
  logic          food_valid_q, food_valid_d;
  logic [VW-1:0] food_v_q, food_v_d;
  logic [HW-1:0] food_h_q, food_h_d;

  logic [HW-1:0] probe_h, next_h;
  logic [VW-1:0] probe_v, next_v;
  logic          probe_ok, next_ok;
  logic          tries_done, cell_empty, at_last;

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // Candidate held by the LFSR during this cycle, and the one it will hold next cycle.
  // Rd* are registered, so a read for a PROBE cycle is set up from next_*.
  assign probe_h  = lfsr_q[HW-1:0];
  assign probe_v  = lfsr_q[8 +: VW];
  assign probe_ok = (probe_h <= H_LAST) && (probe_v <= V_LAST);
  assign next_h   = lfsr_next[HW-1:0];
  assign next_v   = lfsr_next[8 +: VW];
  assign next_ok  = (next_h <= H_LAST) && (next_v <= V_LAST);

  assign tries_inc  = tries_q + TW'(1);
  assign tries_done = (tries_inc == TRIES_MAX);
  assign cell_empty = (RdData == BLOCK_EMPTY);
  assign at_last    = (rd_v_q == V_LAST) && (rd_h_q == H_LAST);

  // NOTE: every signal written here gets its default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    rd_en_d      = 1'b0;
    rd_v_d       = rd_v_q;
    rd_h_d       = rd_h_q;
    busy_d       = busy_q;
    failed_d     = failed_q;
    food_valid_d = food_valid_q;
    food_v_d     = food_v_q;
    food_h_d     = food_h_q;

    case (state_q)
      IDLE: begin
        if (SpawnReq) begin
          state_d      = PROBE;
          busy_d       = 1'b1;
          food_valid_d = 1'b0;
          failed_d     = 1'b0;
          tries_d      = '0;
        end
      end
      PROBE: begin
        if (probe_ok) begin
          state_d = CHECK;
        end else begin
          tries_d = tries_inc;
          state_d = tries_done ? SCAN_RD : PROBE;
        end
      end
      CHECK: begin
        if (cell_empty) begin
          food_v_d = rd_v_q;
          food_h_d = rd_h_q;
          state_d  = FINISH;
        end else begin
          tries_d = tries_inc;
          state_d = tries_done ? SCAN_RD : PROBE;
        end
      end
      SCAN_RD: begin
        state_d = SCAN_CHK;
      end
      SCAN_CHK: begin
        if (cell_empty) begin
          food_v_d = rd_v_q;
          food_h_d = rd_h_q;
          state_d  = FINISH;
        end else if (at_last) begin
          failed_d = 1'b1;
          state_d  = FINISH;
        end else begin
          if (rd_h_q == H_LAST) begin
            rd_h_d = '0;
            rd_v_d = rd_v_q + VW'(1);
          end else begin
            rd_h_d = rd_h_q + HW'(1);
          end
          state_d = SCAN_RD;
        end
      end
      FINISH: begin
        busy_d       = 1'b0;
        food_valid_d = ~failed_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Read strobes are set up on the way into the state that owns the read.
    if (state_d == PROBE && next_ok) begin
      rd_en_d = 1'b1;
      rd_v_d  = next_v;
      rd_h_d  = next_h;
    end else if (state_d == SCAN_RD) begin
      rd_en_d = 1'b1;
      if (state_q != SCAN_CHK) begin
        rd_v_d = '0;
        rd_h_d = '0;
      end
    end

    done_d = (state_d == FINISH);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      tries_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_v_q       <= '0;
      rd_h_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      failed_q     <= 1'b0;
      food_valid_q <= 1'b0;
      food_v_q     <= '0;
      food_h_q     <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_next;
      tries_q      <= tries_d;
      rd_en_q      <= rd_en_d;
      rd_v_q       <= rd_v_d;
      rd_h_q       <= rd_h_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      failed_q     <= failed_d;
      food_valid_q <= food_valid_d;
      food_v_q     <= food_v_d;
      food_h_q     <= food_h_d;
    end
  end

  assign RdEn      = rd_en_q;
  assign RdV       = rd_v_q;
  assign RdH       = rd_h_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Failed    = failed_q;
  assign FoodValid = food_valid_q;
  assign FoodV     = food_v_q;
  assign FoodH     = food_h_q;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: synchronous grid RAM model, software LFSR and a
// small search-timing model supply every expected value.
module tb_food_spawner;

  localparam int          W         = 40;
  localparam int          H         = 30;
  localparam int          MAX_TRIES = 16;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic       SpawnReq = 1'b0;
  logic       RdEn;
  logic [4:0] RdV;
  logic [5:0] RdH;
  logic [1:0] RdData = 2'd0;
  logic       Busy, Done, Failed, FoodValid;
  logic [4:0] FoodV;
  logic [5:0] FoodH;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  grid [H][W];
  logic [15:0] m_lfsr;
  int          done_count = 0;
  int          rd_count = 0;
  int          bad_addr_count = 0;
  int          last_rd_v = -1;
  int          last_rd_h = -1;

  food_spawner dut (
    .Clock(Clock), .ResetN(ResetN), .SpawnReq(SpawnReq),
    .RdEn(RdEn), .RdV(RdV), .RdH(RdH), .RdData(RdData),
    .Busy(Busy), .Done(Done), .Failed(Failed), .FoodValid(FoodValid),
    .FoodV(FoodV), .FoodH(FoodH)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic bit cand_ok(input logic [15:0] l);
    return (int'(l[5:0]) < W) && (int'(l[12:8]) < H);
  endfunction

  // Grid RAM: one cycle read latency.
  always @(posedge Clock)
    if (RdEn && int'(RdV) < H && int'(RdH) < W) RdData <= grid[RdV][RdH];

  always @(posedge Clock or negedge ResetN)
    if (!ResetN) m_lfsr <= SEED;
    else         m_lfsr <= step(m_lfsr);

  always @(negedge Clock) begin
    if (Done) done_count++;
    if (RdEn) begin
      rd_count++;
      last_rd_v = int'(RdV);
      last_rd_h = int'(RdH);
      if (int'(RdV) >= H || int'(RdH) >= W) bad_addr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic fill_grid(input logic [1:0] code);
    for (int v = 0; v < H; v++)
      for (int h = 0; h < W; h++)
        grid[v][h] = (code == 2'd0) ? 2'd0 : ((((v + h) % 2) == 0) ? 2'd1 : 2'd2);
  endtask

  // Expected search outcome given the LFSR value in the first PROBE cycle.
  task automatic predict(input logic [15:0] l0, output int lat, output int fv,
                         output int fh, output bit fail);
    logic [15:0] l;
    int tries, cyc, cv, ch;
    bit found;
    l = l0; tries = 0; cyc = 0; found = 1'b0; fv = -1; fh = -1;
    while (!found && tries < MAX_TRIES) begin
      ch = int'(l[5:0]);
      cv = int'(l[12:8]);
      if (ch >= W || cv >= H) begin
        cyc += 1; l = step(l); tries++;
      end else begin
        cyc += 2; l = step(step(l));
        if (grid[cv][ch] == 2'd0) begin found = 1'b1; fv = cv; fh = ch; end
        else tries++;
      end
    end
    for (int i = 0; i < W * H && !found; i++) begin
      cyc += 2;
      if (grid[i / W][i % W] == 2'd0) begin found = 1'b1; fv = i / W; fh = i % W; end
    end
    fail = !found;
    lat  = cyc + 1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Delay the request until the first PROBE candidate has the wanted validity.
  task automatic align_first_candidate(input bit want_ok);
    int g = 0;
    while (cand_ok(step(m_lfsr)) != want_ok && g < 500) begin
      tick();
      g++;
    end
  endtask

  // Pulse SpawnReq and wait for Done. Returns the cycle index (1 = first PROBE cycle)
  // at which Done was seen, or -1 on timeout. With poke set, SpawnReq is held high from
  // the second busy cycle through the Done cycle.
  task automatic spawn(input string tag, input int budget, input bit poke,
                       output int lat_seen, output logic [15:0] l_probe);
    int c;
    SpawnReq = 1'b1;
    tick();
    SpawnReq = 1'b0;
    l_probe  = m_lfsr;
    check({tag, "_busy"}, Busy, 1'b1);
    check({tag, "_probe_rden"}, RdEn, cand_ok(l_probe));
    c = 1;
    while (!Done && c < budget) begin
      tick();
      c++;
      if (poke) SpawnReq = 1'b1;
    end
    if (Done) lat_seen = c;
    else begin
      lat_seen = -1;
      check({tag, "_timeout"}, 1'b0, 1'b1);
    end
  endtask

  task automatic run_empty_grid(input string tag);
    int lat, fv, fh, got;
    bit fail;
    logic [15:0] lp;
    fill_grid(2'd0);
    align_first_candidate(1'b1);
    spawn(tag, 50, 1'b0, got, lp);
    predict(lp, lat, fv, fh, fail);
    check({tag, "_latency"}, got, 3);
    check({tag, "_failed"}, Failed, 1'b0);
    tick();
    check({tag, "_food_valid"}, FoodValid, 1'b1);
    check({tag, "_food_v"}, FoodV, lp[12:8]);
    check({tag, "_food_h"}, FoodH, lp[5:0]);
    check({tag, "_busy_after"}, Busy, 1'b0);
    check({tag, "_done_pulse"}, Done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, fv, fh, got, dc0;
    bit fail;
    logic [15:0] lp;

    fill_grid(2'd0);

    // Test 1: reset
    tick();
    check("rst_busy", Busy, 1'b0);
    check("rst_rden", RdEn, 1'b0);
    tick();
    ResetN = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("idle_outputs", {Busy, Done, Failed, FoodValid, RdEn}, 5'b0);
    check("idle_rd_addr", {RdV, RdH}, 11'd0);
    check("idle_food", {FoodV, FoodH}, 11'd0);
    check("idle_no_reads", rd_count, 0);

    // Test 2: empty grid, first candidate in range
    run_empty_grid("t2");

    // Test 3: only (5,7) free
    fill_grid(2'd1);
    grid[5][7] = 2'd0;
    align_first_candidate(1'b1);
    spawn("t3", 3000, 1'b0, got, lp);
    predict(lp, lat, fv, fh, fail);
    check("t3_latency", got, lat);
    check("t3_failed", Failed, 1'b0);
    tick();
    check("t3_food_valid", FoodValid, 1'b1);
    check("t3_food_v", FoodV, 5);
    check("t3_food_h", FoodH, 7);

    // Test 4: full grid
    fill_grid(2'd1);
    spawn("t4", 3000, 1'b0, got, lp);
    predict(lp, lat, fv, fh, fail);
    check("t4_latency", got, lat);
    check("t4_within_worst", got <= 2 + MAX_TRIES * 2 + 2 * W * H + 1, 1'b1);
    check("t4_failed", Failed, 1'b1);
    tick();
    check("t4_food_valid", FoodValid, 1'b0);
    check("t4_last_rd_v", last_rd_v, 29);
    check("t4_last_rd_h", last_rd_h, 39);
    check("t4_rd_addr_hold", {RdV, RdH}, {5'd29, 6'd39});

    // Test 5: out-of-range first candidate counts as a try; requests while busy ignored
    fill_grid(2'd1);
    grid[5][7] = 2'd0;
    align_first_candidate(1'b0);
    dc0 = done_count;
    spawn("t5", 3000, 1'b1, got, lp);
    predict(lp, lat, fv, fh, fail);
    check("t5_latency", got, lat);
    tick();
    SpawnReq = 1'b0;
    check("t5_food", {FoodV, FoodH}, {5'd5, 6'd7});
    for (int i = 0; i < 6; i++) tick();
    check("t5_not_restarted", Busy, 1'b0);
    check("t5_one_done", done_count - dc0, 1);

    // Test 6: reset in the middle of a scan
    fill_grid(2'd1);
    SpawnReq = 1'b1;
    tick();
    SpawnReq = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("t6_busy_mid_scan", Busy, 1'b1);
    ResetN = 1'b0;
    #1;
    check("t6_async_drop", {Busy, Done, RdEn, Failed, FoodValid}, 5'b0);
    tick();
    tick();
    ResetN = 1'b1;
    tick();
    check("t6_idle_after_reset", Busy, 1'b0);
    run_empty_grid("t6");

    check("rd_addr_in_range", bad_addr_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
